gen_register_file: RTL

Parametrised multi-entry general-purpose register file for the datapath. It generalises the single enable/clear register into DEPTH entries of WIDTH bits. Features: two asynchronous read ports, one byte-enabled synchronous write port, optional hardwired-zero R0, optional write-to-read bypass, and a per-register pending-write scoreboard. It sits between the instruction decode stage (read addresses, reservations) and the writeback stage (write port).

---
 rtl/gen_register_file.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/gen_register_file.sv
// ---------------------------------------------------------------------------
// gen_register_file
//
// Multi-entry general-purpose register file for the datapath: DEPTH entries
// of WIDTH bits, two combinational read ports, one byte-enabled synchronous
// write port, an optional hardwired-zero R0, optional write-to-read bypass
// and a per-register pending-write scoreboard.
//
// Ports:
//   clk                  clock; all state updates on the rising edge
//   clr                  synchronous active-high reset (dominates all else)
//   wr_en/wr_addr        write strobe and destination register
//   wr_data/wr_be        write data and per-byte enables
//   rd_addr_a/rd_data_a  read port A (combinational)
//   rd_addr_b/rd_data_b  read port B (combinational)
//   resv_en/resv_addr    reserve a destination register (sets pending bit)
//   busy_a/busy_b        pending-write status of the read addresses
//   pend_count           registered number of pending registers
// ---------------------------------------------------------------------------
module gen_register_file #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [WIDTH/8-1:0]         wr_be,
  input  logic [ADDR_W-1:0]          rd_addr_a,
  output logic [WIDTH-1:0]           rd_data_a,
  input  logic [ADDR_W-1:0]          rd_addr_b,
  output logic [WIDTH-1:0]           rd_data_b,
  input  logic                       resv_en,
  input  logic [ADDR_W-1:0]          resv_addr,
  output logic                       busy_a,
  output logic                       busy_b,
  output logic [$clog2(DEPTH+1)-1:0] pend_count
);

  localparam int                NBYTES  = WIDTH / 8;
  localparam int                CNT_W   = $clog2(DEPTH + 1);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if ((WIDTH % 8) != 0) begin : g_bad_width
    $error("gen_register_file: WIDTH must be a multiple of 8");
  end

  // Storage and scoreboard state.
  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [CNT_W-1:0] r_pend_count;

  // Combinational helpers.
  logic             w_wr_ok;
  logic             w_resv_ok;
  logic [WIDTH-1:0] w_wr_old;
  logic [WIDTH-1:0] w_wr_merged;
  logic [DEPTH-1:0] w_pend_nxt;
  logic [CNT_W-1:0] w_pend_cnt_nxt;
  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [WIDTH-1:0]  w_rd_data [2];
  logic              w_busy    [2];

  // Addresses at or beyond DEPTH do not exist when DEPTH is not a power of two.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_L;
  endfunction

  function automatic logic is_r0(input logic [ADDR_W-1:0] addr);
    return (R0_ZERO != 0) && (addr == '0);
  endfunction

  // A write or reservation only takes effect on a real, writable register;
  // everything downstream keys off these qualified strobes.
  assign w_wr_ok   = wr_en   && in_range(wr_addr)   && !is_r0(wr_addr);
  assign w_resv_ok = resv_en && in_range(resv_addr) && !is_r0(resv_addr);

  // Post-write value of the target register: new bytes where enabled,
  // stored bytes elsewhere. Feeds both the array update and the bypass.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_wr_old = '0;
    if (in_range(wr_addr)) begin
      w_wr_old = r_regs[wr_addr];
    end
    for (int i = 0; i < NBYTES; i++) begin
      w_wr_merged[8*i +: 8] = wr_be[i] ? wr_data[8*i +: 8] : w_wr_old[8*i +: 8];
    end
  end

  // Next scoreboard state: the write retires first, then a reservation to the
  // same register re-arms it, so a simultaneous set wins over the clear.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_ok) begin
      w_pend_nxt[wr_addr] = 1'b0;
    end
    if (w_resv_ok) begin
      w_pend_nxt[resv_addr] = 1'b1;
    end
  end

  // Population count of the next pending vector, registered alongside it so
  // pend_count and the pending bits never disagree.
  always_comb begin
    w_pend_cnt_nxt = '0;
    for (int r = 0; r < DEPTH; r++) begin
      w_pend_cnt_nxt = w_pend_cnt_nxt + CNT_W'(w_pend_nxt[r]);
    end
  end

  // Both read ports share one description; they are fully independent.
  assign w_rd_addr[0] = rd_addr_a;
  assign w_rd_addr[1] = rd_addr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd_data[p] = '0;
      w_busy[p]    = 1'b0;
      if (in_range(w_rd_addr[p]) && !is_r0(w_rd_addr[p])) begin
        w_rd_data[p] = r_regs[w_rd_addr[p]];
        w_busy[p]    = r_pend[w_rd_addr[p]];
        if ((BYPASS != 0) && w_wr_ok && (wr_addr == w_rd_addr[p])) begin
          w_rd_data[p] = w_wr_merged;
          // The forwarded value is final unless a new producer claims the
          // register in this same cycle.
          if (!(w_resv_ok && (resv_addr == w_rd_addr[p]))) begin
            w_busy[p] = 1'b0;
          end
        end
      end
    end
  end

  assign rd_data_a  = w_rd_data[0];
  assign rd_data_b  = w_rd_data[1];
  assign busy_a     = w_busy[0];
  assign busy_b     = w_busy[1];
  assign pend_count = r_pend_count;

  // NOTE: clr must zero every entry, so the array is built from resettable
  // flops rather than inferred as a RAM macro, which cannot be bulk-cleared.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int r = 0; r < DEPTH; r++) begin
        r_regs[r] <= '0;
      end
      r_pend       <= '0;
      r_pend_count <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[wr_addr] <= w_wr_merged;
      end
      r_pend       <= w_pend_nxt;
      r_pend_count <= w_pend_cnt_nxt;
    end
  end

endmodule
